// File: rtl/exec_ctrl_6_bit_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctrl_6_bit_pkg
//
// Shared definitions for the 6-bit execute controller slice:
//   - datapath width and register file geometry
//   - ALU opcode encodings (LDI reuses the spare opcode slot)
//   - controller FSM state encodings
//   - instruction field bit positions and a decoded-field struct
//   - helpers to slice an instruction word and to map an opcode onto the
//     ALU op select
// ---------------------------------------------------------------------------
package exec_ctrl_6_bit_pkg;

  // The ALU is hard-wired to 6 bits and the register fields are 2 bits wide,
  // so neither of these can be changed without changing the ISA.
  localparam int DATA_W = 6;
  localparam int NREGS  = 4;
  localparam int REG_AW = 2;
  localparam int OP_W   = 2;

  // Instruction field positions: op=[5:4], rd=[3:2], rs=[1:0].
  localparam int OP_MSB = 5;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  // Opcodes. The first three match the ALU op select encodings directly.
  typedef enum logic [OP_W-1:0] {
    OP_OR  = 2'd0,
    OP_ADD = 2'd1,
    OP_ROL = 2'd2,
    OP_LDI = 2'd3
  } op_e;

  // Controller states. Encoding 3 is unused and recovers to FETCH.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    EXEC  = 2'd2
  } state_e;

  // Latched instruction fields.
  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
  } instr_t;

  // Slice a raw instruction word into its fields.
  function automatic instr_t decode_instr(input logic [DATA_W-1:0] word);
    instr_t f;
    f.op = op_e'(word[OP_MSB:OP_LSB]);
    f.rd = word[RD_MSB:RD_LSB];
    f.rs = word[RS_MSB:RS_LSB];
    return f;
  endfunction

  // LDI never reaches the ALU, so its op select is parked at OR (0) to keep
  // the ALU inputs in a known, harmless configuration.
  function automatic logic [OP_W-1:0] alu_op_of(input op_e op);
    logic [OP_W-1:0] sel;
    if (op == OP_LDI) begin
      sel = '0;
    end else begin
      sel = op;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_4x6.sv
// ---------------------------------------------------------------------------
// regfile_4x6
//
// 4-entry x 6-bit register file for the execute controller.
//
// Ports:
//   clk        in   clock, write on rising edge
//   rst_n      in   asynchronous active-low clear of all entries
//   rd_a_idx   in   read port A index (operand a)
//   rd_b_idx   in   read port B index (operand b)
//   dbg_idx    in   debug read port index
//   wr_en      in   write enable
//   wr_idx     in   write index
//   wr_data    in   write data
//   rd_a_data  out  entry[rd_a_idx], combinational
//   rd_b_data  out  entry[rd_b_idx], combinational
//   dbg_data   out  entry[dbg_idx], combinational
//
// All read ports return the stored value, never the value being written in
// the same cycle; a write only becomes visible after the clock edge.
// ---------------------------------------------------------------------------
module regfile_4x6
  import exec_ctrl_6_bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_a_idx,
  input  logic [REG_AW-1:0] rd_b_idx,
  input  logic [REG_AW-1:0] dbg_idx,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Single synchronous write port with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_a_data = regs[rd_a_idx];
  assign rd_b_data = regs[rd_b_idx];
  assign dbg_data  = regs[dbg_idx];

endmodule

// File: rtl/exec_ctrl_6_bit.sv
// ---------------------------------------------------------------------------
// exec_ctrl_6_bit
//
// Execute controller sitting directly upstream of the 6-bit ALU. It accepts
// instruction words over a valid/ready handshake, reads operands from a
// 4x6 register file, drives the ALU, and writes the ALU result and flags
// back. The latched carry is fed back as the ALU carry-in so that
// rotate-through-carry chains across instructions.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   instr        in   instruction or LDI immediate word
//   instr_valid  in   instr holds a valid word
//   instr_ready  out  word is accepted this cycle when valid is also high
//   alu_a        out  ALU operand a = reg[rd]
//   alu_b        out  ALU operand b = reg[rs]
//   alu_op       out  ALU op select (0 while an LDI is latched)
//   alu_cf_prev  out  ALU carry-in = latched carry flag
//   alu_r        in   ALU result (combinational)
//   alu_cf       in   ALU carry flag
//   alu_sf       in   ALU sign flag
//   alu_zf       in   ALU zero flag
//   cf, sf, zf   out  latched flags
//   retire       out  registered one-cycle pulse per completed instruction
//   dbg_sel      in   register file debug read index
//   dbg_data     out  reg[dbg_sel], combinational
// ---------------------------------------------------------------------------
module exec_ctrl_6_bit
  import exec_ctrl_6_bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_cf_prev,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_cf,
  input  logic              alu_sf,
  input  logic              alu_zf,
  output logic              cf,
  output logic              sf,
  output logic              zf,
  output logic              retire,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q;
  state_e            state_d;
  instr_t            fields_q;
  instr_t            fields_in;
  logic              accept;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              flag_we;
  logic              retire_d;

  assign fields_in = decode_instr(instr);
  assign accept    = instr_valid && instr_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. EXEC always lasts exactly one cycle; IMM waits as long
  // as it takes for the immediate word to show up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          state_d = (fields_in.op == OP_LDI) ? IMM : EXEC;
        end
      end
      IMM: begin
        if (instr_valid) begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output / datapath control. The controller is never ready in EXEC, which
  // is what forces the source to hold the next word for a cycle and caps
  // throughput at one ALU instruction per two cycles.
  always_comb begin
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = instr;
    flag_we     = 1'b0;
    retire_d    = 1'b0;
    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
      end
      IMM: begin
        instr_ready = 1'b1;
        rf_we       = instr_valid;
        rf_wdata    = instr;
        retire_d    = instr_valid;
      end
      EXEC: begin
        rf_we    = 1'b1;
        rf_wdata = alu_r;
        flag_we  = 1'b1;
        retire_d = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  // Instruction fields are captured only when an opcode word is taken in
  // FETCH; the LDI immediate word must not overwrite them because rd still
  // selects the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q <= '{op: OP_OR, rd: '0, rs: '0};
    end else if (accept && (state_q == FETCH)) begin
      fields_q <= fields_in;
    end
  end

  // Flag latch. LDI leaves the flags alone, so only EXEC updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf <= 1'b0;
      sf <= 1'b0;
      zf <= 1'b0;
    end else if (flag_we) begin
      cf <= alu_cf;
      sf <= alu_sf;
      zf <= alu_zf;
    end
  end

  // Retire is registered so it appears in the cycle after writeback. Both
  // retiring states return to FETCH, which never retires, so the pulse can
  // never stretch over two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire <= 1'b0;
    end else begin
      retire <= retire_d;
    end
  end

  regfile_4x6 u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_idx  (fields_q.rd),
    .rd_b_idx  (fields_q.rs),
    .dbg_idx   (dbg_sel),
    .wr_en     (rf_we),
    .wr_idx    (fields_q.rd),
    .wr_data   (rf_wdata),
    .rd_a_data (alu_a),
    .rd_b_data (alu_b),
    .dbg_data  (dbg_data)
  );

  assign alu_op      = alu_op_of(fields_q.op);
  assign alu_cf_prev = cf;

endmodule

// File: tb/tb_exec_ctrl_6_bit.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl_6_bit
//
// Bench for exec_ctrl_6_bit. A behavioural 6-bit ALU closes the loop around
// the controller. Each issued instruction pushes its expected writeback
// value and flags onto a scoreboard queue; a monitor pops one entry per
// retire pulse and compares against the register just written (visible on
// alu_a, since rd is still latched in FETCH) and the latched flags.
// ---------------------------------------------------------------------------
module tb_exec_ctrl_6_bit;

  typedef struct {
    logic [5:0] val;
    logic       cf;
    logic       sf;
    logic       zf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_cf_prev;
  logic [5:0] alu_r;
  logic       alu_cf;
  logic       alu_sf;
  logic       alu_zf;
  logic       cf;
  logic       sf;
  logic       zf;
  logic       retire;
  logic [1:0] dbg_sel = '0;
  logic [5:0] dbg_data;

  int   checks = 0;
  int   failures = 0;
  int   retire_count = 0;
  exp_t sb[$];

  logic [5:0] m_reg [4];
  logic       m_cf;
  logic       m_sf;
  logic       m_zf;

  always #5 clk = ~clk;

  exec_ctrl_6_bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_cf_prev (alu_cf_prev),
    .alu_r       (alu_r),
    .alu_cf      (alu_cf),
    .alu_sf      (alu_sf),
    .alu_zf      (alu_zf),
    .cf          (cf),
    .sf          (sf),
    .zf          (zf),
    .retire      (retire),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // Behavioural ALU: returns {carry, result}. ROL rotates through carry.
  function automatic logic [6:0] alu_fn(input logic [1:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input logic cin);
    logic [6:0] res;
    case (op)
      2'd0:    res = {1'b0, a | b};
      2'd1:    res = {1'b0, a} + {1'b0, b};
      2'd2:    res = {a[5], a[4:0], cin};
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    {alu_cf, alu_r} = alu_fn(alu_op, alu_a, alu_b, alu_cf_prev);
    alu_sf = alu_r[5];
    alu_zf = (alu_r == 6'd0);
  end

  task automatic monitor_retire();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && retire) begin
        retire_count++;
        checks++;
        if (prev) begin
          failures++;
          $display("[TB] FAIL retire_pulse: got retire high two cycles running, required single pulse");
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL retire_unexpected: got retire with empty scoreboard, required none");
        end else begin
          e = sb.pop_front();
          if (alu_a !== e.val) begin
            failures++;
            $display("[TB] FAIL wb_value: got %h required %h", alu_a, e.val);
          end
          checks++;
          if ({cf, sf, zf} !== {e.cf, e.sf, e.zf}) begin
            failures++;
            $display("[TB] FAIL wb_flags: got cf/sf/zf=%b required %b", {cf, sf, zf},
                     {e.cf, e.sf, e.zf});
          end
        end
      end
      prev = retire;
    end
  endtask

  // Presents a word and waits (bounded) until it is taken; returns the
  // number of cycles spent stalled on instr_ready=0. Called at a negedge.
  task automatic push_word(input logic [5:0] w, output int stalls);
    stalls = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got instr_ready=0 for %0d cycles, required 1", stalls);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic issue_ldi(input logic [1:0] rd, input logic [5:0] imm);
    int s;
    m_reg[rd] = imm;
    sb.push_back('{val: imm, cf: m_cf, sf: m_sf, zf: m_zf});
    push_word({2'b11, rd, 2'b00}, s);
    push_word(imm, s);
  endtask

  task automatic issue_alu(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           output int stalls);
    logic [6:0] res;
    res = alu_fn(op, m_reg[rd], m_reg[rs], m_cf);
    m_reg[rd] = res[5:0];
    m_cf = res[6];
    m_sf = res[5];
    m_zf = (res[5:0] == 6'd0);
    sb.push_back('{val: m_reg[rd], cf: m_cf, sf: m_sf, zf: m_zf});
    push_word({op, rd, rs}, stalls);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending retires, required 0", sb.size());
    end
  endtask

  task automatic check_reg(input logic [1:0] idx, input logic [5:0] expv, input string name);
    dbg_sel = idx;
    #1;
    checks++;
    if (dbg_data !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got r%0d=%h required %h", name, idx, dbg_data, expv);
    end
  endtask

  task automatic check_flags(input logic [2:0] expv, input string name);
    checks++;
    if ({cf, sf, zf} !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got cf/sf/zf=%b required %b", name, {cf, sf, zf}, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_cf = 1'b0;
    m_sf = 1'b0;
    m_zf = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_ready, retire, alu_op} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got ready/retire/op=%b required 1000",
               {instr_ready, retire, alu_op});
    end
    check_flags(3'b000, "reset_flags");
    for (int i = 0; i < 4; i++) check_reg(2'(i), 6'h00, "reset_reg");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int s;
    int rc0;
    rc0 = retire_count;
    issue_ldi(2'd0, 6'h05);
    issue_ldi(2'd1, 6'h03);
    issue_alu(2'd1, 2'd0, 2'd1, s);
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL exec_ready: got %b required 0", instr_ready);
    end
    check_reg(2'd0, 6'h05, "dbg_old_during_write");
    drain();
    check_reg(2'd0, 6'h08, "add_r0");
    check_flags(3'b000, "add_flags");
    checks++;
    if (retire_count - rc0 != 3) begin
      failures++;
      $display("[TB] FAIL add_retires: got %0d required 3", retire_count - rc0);
    end
  endtask

  task automatic test_carry_chain();
    int s;
    issue_ldi(2'd2, 6'h3F);
    issue_ldi(2'd3, 6'h01);
    issue_alu(2'd1, 2'd2, 2'd3, s);
    drain();
    check_reg(2'd2, 6'h00, "carry_r2");
    check_flags(3'b101, "carry_flags");
    issue_alu(2'd2, 2'd0, 2'd0, s);
    checks++;
    if ({alu_cf_prev, alu_op} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL rol_carry_in: got cf_prev/op=%b required 110", {alu_cf_prev, alu_op});
    end
    drain();
    check_reg(2'd0, 6'h11, "rol_r0");
  endtask

  task automatic test_or();
    int s;
    issue_ldi(2'd0, 6'h21);
    issue_ldi(2'd1, 6'h12);
    issue_alu(2'd0, 2'd0, 2'd1, s);
    drain();
    check_reg(2'd0, 6'h33, "or_r0");
    check_flags(3'b010, "or_flags");
  endtask

  task automatic test_back_to_back();
    int s;
    int rc0;
    logic [1:0] rds [4];
    logic [1:0] rss [4];
    rds = '{2'd0, 2'd1, 2'd2, 2'd3};
    rss = '{2'd1, 2'd1, 2'd0, 2'd2};
    rc0 = retire_count;
    for (int i = 0; i < 4; i++) begin
      issue_alu(2'd1, rds[i], rss[i], s);
      checks++;
      if (s != ((i == 0) ? 0 : 1)) begin
        failures++;
        $display("[TB] FAIL b2b_stall%0d: got %0d stall cycles required %0d", i, s,
                 (i == 0) ? 0 : 1);
      end
    end
    drain();
    checks++;
    if (retire_count - rc0 != 4) begin
      failures++;
      $display("[TB] FAIL b2b_retires: got %0d required 4", retire_count - rc0);
    end
    for (int i = 0; i < 4; i++) check_reg(2'(i), m_reg[i], "b2b_reg");
  endtask

  task automatic test_imm_stall();
    int s;
    int rc0;
    logic [5:0] old;
    logic [2:0] fl;
    old = m_reg[3];
    fl = {m_cf, m_sf, m_zf};
    m_reg[3] = 6'h2A;
    sb.push_back('{val: 6'h2A, cf: m_cf, sf: m_sf, zf: m_zf});
    push_word(6'h3C, s);
    rc0 = retire_count;
    repeat (5) @(negedge clk);
    check_reg(2'd3, old, "imm_stall_hold");
    checks++;
    if (instr_ready !== 1'b1 || retire_count != rc0) begin
      failures++;
      $display("[TB] FAIL imm_stall_state: got ready=%b retires=%0d required 1/0", instr_ready,
               retire_count - rc0);
    end
    push_word(6'h2A, s);
    drain();
    check_reg(2'd3, 6'h2A, "imm_r3");
    check_flags(fl, "imm_flags");
  endtask

  task automatic test_reset_mid_exec();
    int s;
    int rc0;
    rc0 = retire_count;
    push_word(6'h11, s);
    #2;
    rst_n = 1'b0;
    #1;
    check_flags(3'b000, "abort_flags");
    checks++;
    if ({retire, instr_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL abort_ctrl: got retire/ready=%b required 01", {retire, instr_ready});
    end
    for (int i = 0; i < 4; i++) check_reg(2'(i), 6'h00, "abort_reg");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || retire_count != rc0) begin
      failures++;
      $display("[TB] FAIL abort_after: got ready=%b retires=%0d required 1/0", instr_ready,
               retire_count - rc0);
    end
    issue_ldi(2'd2, 6'h15);
    drain();
    check_reg(2'd2, 6'h15, "post_reset_ldi");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fork
      monitor_retire();
    join_none
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_or();
    test_back_to_back();
    test_imm_stall();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_6_bit.md
Name: exec_ctrl_6_bit

Overview:
Execute controller that sits directly upstream of the 6-bit ALU and consumes its outputs.
- Accepts 6-bit instruction words over a valid/ready handshake.
- Holds a 4-entry x 6-bit register file and reads operands from it.
- Drives the ALU operand, op and carry-in inputs, then writes the ALU result back and latches the CF/SF/ZF flags.
- The latched CF is fed back as the ALU carry-in, which closes the rotate-through-carry loop.

Parameters:
DATA_W, 6, datapath width; fixed by the ALU; no other value is supported.
NREGS, 4, register file depth; fixed by the 2-bit register fields.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
instr  input  6  instruction or immediate word.
instr_valid  input  1  instr holds a valid word.
instr_ready  output  1  controller accepts instr this cycle.
alu_a  output  6  ALU operand a = reg[rd].
alu_b  output  6  ALU operand b = reg[rs].
alu_op  output  2  ALU op select.
alu_cf_prev  output  1  carry-in to ALU = latched CF.
alu_r  input  6  ALU result (combinational).
alu_cf  input  1  ALU carry flag.
alu_sf  input  1  ALU sign flag.
alu_zf  input  1  ALU zero flag.
cf  output  1  latched carry flag.
sf  output  1  latched sign flag.
zf  output  1  latched zero flag.
retire  output  1  one-cycle pulse when an instruction completes.
dbg_sel  input  2  register file debug read index.
dbg_data  output  6  reg[dbg_sel], combinational.

Behaviour:
Clock and reset:
- Single clock, clk.
- Reset is rst_n, asynchronous and active-low.
- On reset: FSM=FETCH; all registers 0; cf=sf=zf=0; retire=0; latched instruction fields 0.
- Reset deassertion is synchronous to clk.

Instruction format:
- op=instr[5:4], rd=instr[3:2], rs=instr[1:0].
- op 0=OR, 1=ADD, 2=ROL (ALU encodings).
- op 3=LDI: the next accepted word is an immediate written to rd.

FSM states FETCH, IMM, EXEC:
- FETCH: instr_ready=1. On instr_valid, latch op/rd/rs. If op==3, go to IMM; otherwise go to EXEC. If instr_valid=0, stay in FETCH.
- IMM: instr_ready=1. On instr_valid, reg[rd]<=instr, retire=1 next cycle, go to FETCH. Flags are unchanged. If no word arrives, stay in IMM indefinitely.
- EXEC: instr_ready=0. Drive alu_a=reg[rd], alu_b=reg[rs], alu_op=op, alu_cf_prev=cf. At the clock edge: reg[rd]<=alu_r; cf/sf/zf<=alu_cf/alu_sf/alu_zf; retire=1 next cycle; go to FETCH.

Latency:
- ALU instruction: 2 cycles from accept to writeback, so peak throughput is 1 instruction per 2 cycles.
- LDI: 2 accepted words.

ALU outputs in FETCH/IMM:
- alu_a/alu_b still reflect reg[rd]/reg[rs] of the latched fields.
- alu_op is held at the latched op, or 0 when op==3.
- The ALU result is ignored outside EXEC.

Boundary rules:
- rd==rs is legal; both operands read the pre-write value.
- Write and debug read of the same register in one cycle: dbg_data shows the old value until the edge.
- Handshake: a word is transferred only when instr_valid && instr_ready. Words presented in EXEC are not consumed and must be held by the source.
- Reset asserted mid-IMM or mid-EXEC: the instruction is aborted with no writeback and no retire, and everything returns to reset values.
- retire is a registered single-cycle pulse; it is never high for two consecutive cycles.

Decomposition:
- Shared package constants:
  - OP_OR=0, OP_ADD=1, OP_ROL=2, OP_LDI=3.
  - State encodings FETCH=0, IMM=1, EXEC=2.
  - Field bit positions.
- One natural sub-module: regfile_4x6 (2 combinational read ports plus debug read port, 1 synchronous write port, async active-low clear).
- FSM and flag latch live in exec_ctrl_6_bit.
- The ALU is instantiated alongside this block at the top level, not inside it.

Test Plan:
1. LDI r0,5 (words 0x30, 0x05); LDI r1,3 (0x34, 0x03); ADD r0,r1 (0x11) -> dbg r0=8, cf=0, sf=0, zf=0; retire pulses 3 times.
2. LDI r2,0x3F; LDI r3,0x01; ADD r2,r3 (0x1B) -> r2=0x00, cf=1, zf=1, sf=0; the following instruction sees alu_cf_prev=1.
3. LDI r0,0x21; LDI r1,0x12; OR r0,r1 (0x01) -> r0=0x33, sf=1, cf=0, zf=0.
4. Backpressure: hold instr_valid=1 with back-to-back ADD words -> instr_ready is low every EXEC cycle; each word is accepted exactly once; one retire per 2 cycles.
5. Stall in IMM: send 0x3C, then instr_valid=0 for 5 cycles, then 0x2A -> r3=0x2A written only after the immediate arrives; flags unchanged.
6. Reset mid-EXEC: assert rst_n=0 asynchronously during EXEC of ADD r0,r1 -> immediately all registers 0, cf/sf/zf=0, retire=0; after release the FSM is in FETCH with instr_ready=1.
